// File: rtl/lcd_text_pkg.sv
// Shared types, character constants and menu text for lcd_text_composer.
//  state_t      : composer FSM states
//  CH_SPACE/UNK : blank and unknown-digit characters
//  TXT_*        : 16-char menu rows, char 0 in [127:120]
//  digit_ascii  : BCD nibble -> '0'..'9', '?' for 10..15
package lcd_text_pkg;

  typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, ASSEMBLE, PRESENT} state_t;

  localparam logic [7:0]   CH_SPACE  = 8'h20;
  localparam logic [7:0]   CH_UNK    = "?";
  localparam logic [127:0] ROW_BLANK = {16{CH_SPACE}};

  // Literals are right-justified with NUL fill; move the text to char 0
  // and back-fill with spaces.
  function automatic logic [127:0] pad16(input logic [127:0] s);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < 16; i++)
      if (r[127:120] == 8'h00) r = {r[119:0], CH_SPACE};
    return r;
  endfunction

  localparam logic [127:0] TXT_COTTON = pad16(128'(" Cotton"));
  localparam logic [127:0] TXT_WOODY  = pad16(128'(" Woody"));
  localparam logic [127:0] TXT_CITRUS = pad16(128'(" Citrus"));
  localparam logic [127:0] TXT_T30    = pad16(128'(" Timer 30min"));
  localparam logic [127:0] TXT_T60    = pad16(128'(" Timer 60min"));
  localparam logic [127:0] TXT_T120   = pad16(128'(" Timer 120min"));

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d > 4'd9) ? CH_UNK : (8'h30 + {4'h0, d});
  endfunction

  function automatic logic [127:0] scent_row(input logic [1:0] lr);
    case (lr)
      2'd0:    return TXT_COTTON;
      2'd1:    return TXT_WOODY;
      default: return TXT_CITRUS;
    endcase
  endfunction

  function automatic logic [127:0] timer_row(input logic [1:0] ud);
    case (ud)
      2'd0:    return TXT_T30;
      2'd1:    return TXT_T60;
      2'd2:    return TXT_T120;
      default: return ROW_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
//  start : 1-cycle pulse, samples bin
//  done  : 1-cycle pulse ADC_W+1 cycles after start
//  bcd   : DIGITS packed BCD digits, MS digit on top, held until the next result
module bin2bcd_seq #(
  parameter int ADC_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADC_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(ADC_W + 1);

  logic                busy;
  logic [CW-1:0]       cnt;
  logic [ADC_W-1:0]    sh;
  logic [4*DIGITS-1:0] acc, adj;

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++)
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      acc  <= '0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= CW'(ADC_W);
        sh   <= bin;
        acc  <= '0;
      end else if (busy) begin
        if (cnt != '0) begin
          acc <= {adj[4*DIGITS-2:0], sh[ADC_W-1]};
          sh  <= sh << 1;
          cnt <= cnt - 1'b1;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= acc;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_text_composer.sv
// Builds 16x2 LCD frames (menu, environment or ADC page) on a refresh tick
// and offers them to the LCD driver over frame_valid/frame_ready.
//  clk, rst (async, active-high)
//  sw, btn_LR, btn_UD, humidity10/0, temperature10/0, page_next, adc_data : view inputs
//  row1, row2  : ASCII rows, char 0 in [127:120]
//  frame_valid / frame_ready : frame handshake to the driver
// Optional feature: `define CURSOR_BLINK_EN puts a blinking '>' in col 0 of
// row1 in the menu view; without it col 0 stays ' '.
module lcd_text_composer
  import lcd_text_pkg::*;
#(
  parameter int ADC_W       = 10,
  parameter int N_CH        = 2,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 5_000_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw,
  input  logic [1:0]              btn_LR,
  input  logic [1:0]              btn_UD,
  input  logic [3:0]              humidity10,
  input  logic [3:0]              humidity0,
  input  logic [3:0]              temperature10,
  input  logic [3:0]              temperature0,
  input  logic                    page_next,
  input  logic [N_CH*ADC_W-1:0]   adc_data,
  output logic [127:0]            row1,
  output logic [127:0]            row2,
  output logic                    frame_valid,
  input  logic                    frame_ready
);

  localparam int PAGES = (N_CH + 1) / 2;
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  generate
    if (10**DIGITS <= 2**ADC_W - 1 || DIGITS > 11 || BLINK_DIV < 1)
      begin : g_bad_cfg
        $error("lcd_text_composer: DIGITS too small for ADC_W or bad BLINK_DIV");
      end
  endgenerate

  state_t              state;
  logic [RW-1:0]       ref_cnt;
  logic                tick, evt, pending;
  logic [PW-1:0]       page, page_s;
  logic                sw_s;
  logic [1:0]          lr_s, ud_s;
  logic [3:0]          h10_s, h0_s, t10_s, t0_s;
  logic [ADC_W-1:0]    adc_s [N_CH];
  logic                ch_sel, conv_start, conv_done;
  logic [ADC_W-1:0]    conv_bin;
  logic [4*DIGITS-1:0] conv_bcd, bcd_a, bcd_b;
  logic [127:0]        row1_n, row2_n;
  int                  ch_a;
  logic                has_b;

  assign tick = (ref_cnt == RW'(REFRESH_DIV - 1));

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on, blink_flip;

  assign blink_flip = (blink_cnt == BW'(BLINK_DIV - 1));
  // A phase change is a refresh event so the cursor redraws promptly.
  assign evt = tick | blink_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_flip ? '0 : blink_cnt + 1'b1;
      if (blink_flip) blink_on <= ~blink_on;
    end
  end
`else
  assign evt = tick;
`endif

  always_comb begin
    ch_a  = 2 * int'(page_s);
    has_b = (ch_a + 1 < N_CH);
    conv_bin = '0;
    for (int k = 0; k < N_CH; k++)
      if (k == ch_a + int'(ch_sel)) conv_bin = adc_s[k];
  end

  bin2bcd_seq #(.ADC_W(ADC_W), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // "CHn: dddd" with leading zeros; single-digit channel label.
  function automatic logic [127:0] adc_row(input int ch, input logic [4*DIGITS-1:0] bcd);
    logic [127:0] r;
    r = {"CH", digit_ascii((ch < 10) ? 4'(ch) : 4'hF), ": ", {11{CH_SPACE}}};
    for (int i = 0; i < DIGITS; i++)
      r[127-8*(5+i) -: 8] = digit_ascii(bcd[4*(DIGITS-1-i) +: 4]);
    return r;
  endfunction

  always_comb begin
    row1_n = ROW_BLANK;
    row2_n = ROW_BLANK;
    if (sw_s) begin
      row1_n = adc_row(ch_a, bcd_a);
      if (has_b) row2_n = adc_row(ch_a + 1, bcd_b);
    end else if (lr_s == 2'd3) begin
      row1_n = {"Temp: ", digit_ascii(t10_s), digit_ascii(t0_s), " C", {6{CH_SPACE}}};
      row2_n = {"Humi: ", digit_ascii(h10_s), digit_ascii(h0_s), " %", {6{CH_SPACE}}};
    end else begin
      row1_n = scent_row(lr_s);
      row2_n = timer_row(ud_s);
`ifdef CURSOR_BLINK_EN
      row1_n[127:120] = blink_on ? 8'h3E : CH_SPACE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ref_cnt     <= '0;
      pending     <= 1'b0;
      page        <= '0;
      page_s      <= '0;
      sw_s        <= 1'b0;
      lr_s        <= '0;
      ud_s        <= '0;
      h10_s       <= '0;
      h0_s        <= '0;
      t10_s       <= '0;
      t0_s        <= '0;
      for (int k = 0; k < N_CH; k++) adc_s[k] <= '0;
      ch_sel      <= 1'b0;
      conv_start  <= 1'b0;
      bcd_a       <= '0;
      bcd_b       <= '0;
      row1        <= ROW_BLANK;
      row2        <= ROW_BLANK;
      frame_valid <= 1'b0;
    end else begin
      ref_cnt    <= tick ? '0 : ref_cnt + 1'b1;
      conv_start <= 1'b0;
      if (sw && page_next)
        page <= (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
      // Busy: remember at most one missed refresh.
      if (evt && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: if (evt || pending) begin
          pending <= 1'b0;
          page_s  <= page;
          sw_s    <= sw;
          lr_s    <= btn_LR;
          ud_s    <= btn_UD;
          h10_s   <= humidity10;
          h0_s    <= humidity0;
          t10_s   <= temperature10;
          t0_s    <= temperature0;
          for (int k = 0; k < N_CH; k++) adc_s[k] <= adc_data[k*ADC_W +: ADC_W];
          state   <= SAMPLE;
        end
        SAMPLE: if (sw_s) begin
          ch_sel     <= 1'b0;
          conv_start <= 1'b1;
          state      <= CONVERT;
        end else begin
          state <= ASSEMBLE;
        end
        CONVERT: if (conv_done) begin
          if (!ch_sel) begin
            bcd_a <= conv_bcd;
            if (has_b) begin
              ch_sel     <= 1'b1;
              conv_start <= 1'b1;
            end else begin
              state <= ASSEMBLE;
            end
          end else begin
            bcd_b <= conv_bcd;
            state <= ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          row1        <= row1_n;
          row2        <= row2_n;
          frame_valid <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: if (frame_ready) begin
          frame_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_composer.sv
module tb_lcd_text_composer;

  localparam int ADC_W = 10;
  localparam int N_CH  = 3;
  localparam int REF   = 40;
  localparam int PAGES = (N_CH + 1) / 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  sw = 1'b0;
  logic [1:0]            btn_LR = '0, btn_UD = '0;
  logic [3:0]            humidity10 = '0, humidity0 = '0;
  logic [3:0]            temperature10 = '0, temperature0 = '0;
  logic                  page_next = 1'b0;
  logic [N_CH*ADC_W-1:0] adc_data = '0;
  logic [127:0]          row1, row2;
  logic                  frame_valid;
  logic                  frame_ready = 1'b1;

  lcd_text_composer #(
    .ADC_W(ADC_W), .N_CH(N_CH), .DIGITS(4), .REFRESH_DIV(REF), .BLINK_DIV(1000)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_LR(btn_LR), .btn_UD(btn_UD),
    .humidity10(humidity10), .humidity0(humidity0),
    .temperature10(temperature10), .temperature0(temperature0),
    .page_next(page_next), .adc_data(adc_data),
    .row1(row1), .row2(row2), .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_page = 0;
  logic [ADC_W-1:0] adc_v [N_CH];
  string names [3] = '{" Cotton", " Woody", " Citrus"};
  string mins  [3] = '{"30", "60", "120"};

  typedef struct {
    bit       sw;
    bit [1:0] lr, ud;
    bit [3:0] h10, h0, t10, t0;
    string    e1, e2;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [127:0] pack(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic string dig(input logic [3:0] n);
    if (n > 9) return "?";
    return $sformatf("%0d", n);
  endfunction

  // Expected frame from the current inputs and the tracked page.
  task automatic model_rows(output logic [127:0] e1, output logic [127:0] e2);
    int a;
    if (sw) begin
      a  = 2 * m_page;
      e1 = pack($sformatf("CH%0d: %04d", a, adc_v[a]));
      e2 = (a + 1 < N_CH) ? pack($sformatf("CH%0d: %04d", a + 1, adc_v[a+1])) : pack("");
    end else if (btn_LR == 2'd3) begin
      e1 = pack({"Temp: ", dig(temperature10), dig(temperature0), " C"});
      e2 = pack({"Humi: ", dig(humidity10), dig(humidity0), " %"});
    end else begin
      e1 = pack(names[btn_LR]);
      e2 = (btn_UD == 2'd3) ? pack("") : pack({" Timer ", mins[btn_UD], "min"});
    end
  endtask

  task automatic chk_row(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_adc();
    for (int k = 0; k < N_CH; k++) adc_data[k*ADC_W +: ADC_W] = adc_v[k];
  endtask

  task automatic wait_fv(input string name, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_valid) begin got = 1; break; end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no frame_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_page();
    @(negedge clk) page_next = 1'b1;
    @(negedge clk) page_next = 1'b0;
    if (sw) m_page = (m_page + 1) % PAGES;
  endtask

  // Waits for the next frame and checks it against the model.
  task automatic check_frame(input string name);
    logic [127:0] e1, e2;
    model_rows(e1, e2);
    wait_fv(name, 200);
    chk_row({name, "_row1"}, row1, e1);
    chk_row({name, "_row2"}, row2, e2);
    @(negedge clk);
    chk_int({name, "_fv_pulse"}, int'(frame_valid), 0);
  endtask

  initial begin
    logic [127:0] b1, b2, c1, c2;
    int n, bad, extra;

    tbl[0] = '{1'b0, 2'd1, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0, " Woody",     " Timer 120min"};
    tbl[1] = '{1'b0, 2'd3, 2'd0, 4'd6, 4'hA, 4'd2, 4'd5, "Temp: 25 C", "Humi: 6? %"};
    tbl[2] = '{1'b0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, " Cotton",    " Timer 30min"};
    tbl[3] = '{1'b0, 2'd2, 2'd3, 4'd0, 4'd0, 4'd0, 4'd0, " Citrus",    ""};
    tbl[4] = '{1'b0, 2'd3, 2'd1, 4'd9, 4'd9, 4'hF, 4'd0, "Temp: ?0 C", "Humi: 99 %"};
    tbl[5] = '{1'b0, 2'd1, 2'd1, 4'd0, 4'd0, 4'd0, 4'd0, " Woody",     " Timer 60min"};
    for (int k = 0; k < N_CH; k++) adc_v[k] = '0;

    // Reset state and first-frame latency (tick at cycle REF-1, +3).
    repeat (3) @(negedge clk);
    #1;
    chk_row("rst_row1", row1, pack(""));
    chk_row("rst_row2", row2, pack(""));
    chk_int("rst_fv", int'(frame_valid), 0);
    @(negedge clk) rst = 1'b0;
    n = 0;
    while (!frame_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        chk_row("pre_tick_row1", row1, pack(""));
        chk_row("pre_tick_row2", row2, pack(""));
      end
    end
    chk_int("first_latency", n, REF - 1 + 3);
    chk_row("first_row1", row1, pack(" Cotton"));
    chk_row("first_row2", row2, pack(" Timer 30min"));
    @(negedge clk);
    chk_int("first_fv_pulse", int'(frame_valid), 0);

    // Table-driven menu / environment frames.
    for (int i = 0; i < 6; i++) begin
      sw = tbl[i].sw; btn_LR = tbl[i].lr; btn_UD = tbl[i].ud;
      humidity10 = tbl[i].h10; humidity0 = tbl[i].h0;
      temperature10 = tbl[i].t10; temperature0 = tbl[i].t0;
      wait_fv($sformatf("tbl%0d", i), 200);
      chk_row($sformatf("tbl%0d_row1", i), row1, pack(tbl[i].e1));
      chk_row($sformatf("tbl%0d_row2", i), row2, pack(tbl[i].e2));
      @(negedge clk);
      chk_int($sformatf("tbl%0d_fv_pulse", i), int'(frame_valid), 0);
    end

    // ADC pages with N_CH=3: page 0, odd last page, wrap.
    adc_v[0] = 10'd1023; adc_v[1] = 10'd7; adc_v[2] = 10'd512;
    drive_adc();
    sw = 1'b1;
    wait_fv("adc_p0", 200);
    chk_row("adc_p0_row1", row1, pack("CH0: 1023"));
    chk_row("adc_p0_row2", row2, pack("CH1: 0007"));
    pulse_page();
    wait_fv("adc_p1", 200);
    chk_row("adc_p1_row1", row1, pack("CH2: 0512"));
    chk_row("adc_p1_row2", row2, pack(""));
    pulse_page();
    wait_fv("adc_wrap", 200);
    chk_row("adc_wrap_row1", row1, pack("CH0: 1023"));
    chk_row("adc_wrap_row2", row2, pack("CH1: 0007"));
    @(negedge clk);

    // Randomized frames against the model.
    for (int r = 0; r < 24; r++) begin
      sw = 1'($urandom % 2);
      btn_LR = 2'($urandom % 4); btn_UD = 2'($urandom % 4);
      humidity10 = 4'($urandom % 16); humidity0 = 4'($urandom % 16);
      temperature10 = 4'($urandom % 16); temperature0 = 4'($urandom % 16);
      for (int k = 0; k < N_CH; k++) adc_v[k] = 10'($urandom % 1024);
      drive_adc();
      if ($urandom % 2) pulse_page();
      check_frame($sformatf("rnd%0d", r));
    end

    // Back-pressure: frozen rows over 3 ticks, then exactly one pending frame.
    sw = 1'b0; btn_LR = 2'd0; btn_UD = 2'd0;
    wait_fv("bp_sync", 200);
    @(negedge clk);
    frame_ready = 1'b0;
    btn_LR = 2'd2; btn_UD = 2'd1;
    model_rows(b1, b2);
    wait_fv("bp_hold", 200);
    chk_row("bp_hold_row1", row1, b1);
    chk_row("bp_hold_row2", row2, b2);
    btn_LR = 2'd3;
    temperature10 = 4'd1; temperature0 = 4'd8; humidity10 = 4'd4; humidity0 = 4'd2;
    model_rows(c1, c2);
    bad = 0;
    for (int i = 0; i < 3 * REF + 10; i++) begin
      @(negedge clk);
      if (!frame_valid || row1 !== b1 || row2 !== b2) bad++;
    end
    chk_int("bp_frozen_cycles_bad", bad, 0);
    frame_ready = 1'b1;
    wait_fv("bp_pending", 6);
    chk_row("bp_pending_row1", row1, c1);
    chk_row("bp_pending_row2", row2, c2);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_valid) extra++;
    end
    chk_int("bp_extra_frames", extra, 0);

    // Reset in the middle of an ADC conversion.
    adc_v[0] = 10'd1023; adc_v[1] = 10'd7; adc_v[2] = 10'd512;
    drive_adc();
    sw = 1'b1;
    check_frame("pre_rst");
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_int("midrst_fv", int'(frame_valid), 0);
    chk_row("midrst_row1", row1, pack(""));
    chk_row("midrst_row2", row2, pack(""));
    m_page = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_fv("post_rst", 200);
    chk_row("post_rst_row1", row1, pack("CH0: 1023"));
    chk_row("post_rst_row2", row2, pack("CH1: 0007"));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
